// File: rtl/bus_arbiter.sv
// Round-robin arbiter producing one-hot enables for a shared tristate bus.
// Holds each grant for up to MAX_BURST cycles and inserts one all-off cycle between owners.
module bus_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         en,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 turn
);

  localparam int IW = $clog2(N);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] g_q, g_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [N-1:0]  en_q, en_d;
  logic          busy_q, busy_d;
  logic          turn_q, turn_d;
  logic [IW-1:0] win;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (int'(i) == N - 1) return '0;
    return i + IW'(1);
  endfunction

  // Scan downward so the requester closest to p (smallest offset) is the last write.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] w;
    int j;
    w = p;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= N) j = j - N;
      if (r[IW'(j)]) w = IW'(j);
    end
    return w;
  endfunction

  assign win = pick(req, ptr_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    case (state_q)
      ST_IDLE, ST_TURN: begin
        if (|req) begin
          state_d = ST_GRANT;
          en_d    = N'(1) << win;
          g_d     = win;
          cnt_d   = 4'd1;
        end else begin
          state_d = ST_IDLE;
          en_d    = '0;
        end
      end
      ST_GRANT: begin
        // Releasing owner moves to the back of the queue via ptr.
        if (!req[g_q] || cnt_q == 4'(MAX_BURST)) begin
          state_d = ST_TURN;
          en_d    = '0;
          ptr_d   = next_idx(g_q);
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    turn_d = (state_d == ST_TURN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      turn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      turn_q  <= turn_d;
    end
  end

  assign en     = en_q;
  assign gnt_id = g_q;
  assign busy   = busy_q;
  assign turn   = turn_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic against a rotation-priority model.
module tb_bus_arbiter;
  localparam int N         = 4;
  localparam int MAX_BURST = 4;
  localparam int IW        = $clog2(N);
  localparam int VW        = N + IW + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  en;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          turn;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bus_arbiter #(.N(N), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset), .req(req), .en(en),
    .gnt_id(gnt_id), .busy(busy), .turn(turn)
  );

  always #5 clk = ~clk;

  // Model: an owner (or none), how long it has held, whether the bus is in its
  // quiet cycle, and the index where the next priority search starts.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 0;
  int m_start = 0;
  bit m_turn  = 1'b0;

  always @(posedge clk) begin
    int best, bestd, d;
    cyc++;
    if (reset) begin
      m_owner = -1; m_held = 0; m_last = 0; m_start = 0; m_turn = 1'b0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || m_held == MAX_BURST) begin
        m_start = (m_owner + 1) % N;
        m_owner = -1;
        m_turn  = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      m_turn = 1'b0;
      best = -1; bestd = N;
      for (int i = 0; i < N; i++) begin
        d = (i - m_start + N) % N;
        if (req[i] && d < bestd) begin best = i; bestd = d; end
      end
      if (best >= 0) begin m_owner = best; m_last = best; m_held = 1; end
    end
  end

  function automatic logic [VW-1:0] model_vec();
    logic [N-1:0] e;
    e = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    return {e, IW'(m_last), (m_owner >= 0) || m_turn, m_turn};
  endfunction

  // Present inputs just after a falling edge, return at the next falling edge.
  task automatic do_cycle(input logic [N-1:0] r, input logic rs);
    req = r;
    reset = rs;
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      do_cycle(4'b1111, 1'b1);
      checks++;
      if ({en, gnt_id, busy, turn} !== {4'b0000, 2'd0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got=%b exp=%b", cyc, {en, gnt_id, busy, turn}, 8'b0);
      end
    end
    do_cycle(4'b1111, 1'b0);
    checks++;
    if (en !== 4'b0001) begin
      failures++;
      $display("FAIL reset_release_grant got=%b exp=0001", en);
    end
  endtask

  task automatic test_single_long;
    logic [N-1:0] exp_en;
    do_cycle(4'b0000, 1'b1);
    for (int c = 0; c < 15; c++) begin
      do_cycle(4'b0100, 1'b0);
      exp_en = (c % 5 < 4) ? 4'b0100 : 4'b0000;
      checks++;
      if ({en, gnt_id, turn} !== {exp_en, 2'd2, c % 5 == 4}) begin
        failures++;
        $display("FAIL single_long c=%0d got=%b exp=%b", c, {en, gnt_id, turn}, {exp_en, 2'd2, c % 5 == 4});
      end
      checks++;
      if ({en, gnt_id, busy, turn} !== model_vec()) begin
        failures++;
        $display("FAIL single_long_model c=%0d got=%b exp=%b", c, {en, gnt_id, busy, turn}, model_vec());
      end
    end
  endtask

  task automatic test_full_contention;
    logic [N-1:0] exp_en;
    do_cycle(4'b0000, 1'b1);
    for (int c = 0; c < 25; c++) begin
      do_cycle(4'b1111, 1'b0);
      exp_en = (c % 5 < 4) ? (N'(1) << ((c / 5) % N)) : 4'b0000;
      checks++;
      if (en !== exp_en || $countones(en) > 1) begin
        failures++;
        $display("FAIL contention c=%0d got=%b exp=%b", c, en, exp_en);
      end
      checks++;
      if ({en, gnt_id, busy, turn} !== model_vec()) begin
        failures++;
        $display("FAIL contention_model c=%0d got=%b exp=%b", c, {en, gnt_id, busy, turn}, model_vec());
      end
    end
  endtask

  task automatic test_short_pulse;
    do_cycle(4'b0000, 1'b1);
    do_cycle(4'b0010, 1'b0);
    checks++;
    if ({en, busy, turn} !== {4'b0010, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL pulse_grant got=%b exp=%b", {en, busy, turn}, {4'b0010, 2'b10});
    end
    do_cycle(4'b0000, 1'b0);
    checks++;
    if ({en, busy, turn} !== {4'b0000, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL pulse_turn got=%b exp=%b", {en, busy, turn}, {4'b0000, 2'b11});
    end
    do_cycle(4'b0000, 1'b0);
    checks++;
    if ({en, gnt_id, busy, turn} !== {4'b0000, 2'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL pulse_idle got=%b exp=%b", {en, gnt_id, busy, turn}, {4'b0000, 2'd1, 2'b00});
    end
  endtask

  task automatic test_fairness;
    logic [N-1:0] seq_req [10] = '{4'b0001, 4'b1001, 4'b1000, 4'b1000, 4'b1001,
                                   4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0001};
    logic [N-1:0] seq_en  [10] = '{4'b0001, 4'b0001, 4'b0000, 4'b1000, 4'b1000,
                                   4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001};
    do_cycle(4'b0000, 1'b1);
    for (int c = 0; c < 10; c++) begin
      do_cycle(seq_req[c], 1'b0);
      checks++;
      if (en !== seq_en[c]) begin
        failures++;
        $display("FAIL fairness c=%0d got=%b exp=%b", c, en, seq_en[c]);
      end
    end
  endtask

  task automatic test_mid_reset;
    do_cycle(4'b0000, 1'b1);
    do_cycle(4'b0100, 1'b0);
    do_cycle(4'b0100, 1'b0);
    checks++;
    if (en !== 4'b0100) begin
      failures++;
      $display("FAIL midreset_pre got=%b exp=0100", en);
    end
    do_cycle(4'b1111, 1'b1);
    checks++;
    if ({en, gnt_id, busy, turn} !== 8'b0) begin
      failures++;
      $display("FAIL midreset_drop got=%b exp=%b", {en, gnt_id, busy, turn}, 8'b0);
    end
    do_cycle(4'b1111, 1'b0);
    checks++;
    if ({en, gnt_id} !== {4'b0001, 2'd0}) begin
      failures++;
      $display("FAIL midreset_regrant got=%b exp=%b", {en, gnt_id}, {4'b0001, 2'd0});
    end
  endtask

  task automatic test_random;
    logic [N-1:0] r;
    logic rs;
    do_cycle(4'b0000, 1'b1);
    for (int c = 0; c < 500; c++) begin
      r  = N'($urandom);
      if ($urandom_range(3) == 0) r = '0;
      rs = ($urandom_range(49) == 0);
      do_cycle(r, rs);
      checks++;
      if ({en, gnt_id, busy, turn} !== model_vec() || $countones(en) > 1) begin
        failures++;
        $display("FAIL random c=%0d req=%b got=%b exp=%b", c, r, {en, gnt_id, busy, turn}, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_long();
    test_full_contention();
    test_short_pulse();
    test_fairness();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
